mips_bus_lsu: RTL

MIPS_BUS_LSU -- requirements
Module: mips_bus_lsu

---
 rtl/mips_bus_lsu_if.sv | 38 +++
 rtl/mips_bus_lsu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_lsu_if.sv
// rtl/mips_bus_lsu_if.sv - CPU request/response and Avalon-MM bus signals of the load/store unit
interface mips_bus_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    // LSU side: accepts CPU requests, masters the memory bus
    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  waitrequest, readdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output address, read, write, writedata, byteenable
    );

    // Environment side: CPU plus memory slave
    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output waitrequest, readdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  address, read, write, writedata, byteenable
    );
endinterface

// File: rtl/mips_bus_lsu.sv
// rtl/mips_bus_lsu.sv - queued load/store unit issuing aligned Avalon-MM commands
module lsu_req_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A full queue refuses a push even when the head leaves in the same cycle
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Entry storage, written at the tail
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally; occupancy separates full from empty
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module mips_bus_lsu #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    mips_bus_lsu_if.master bus,
    output logic          busy
);
    localparam int QW = 68;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t      state;
    logic [QW-1:0] q_rdata;
    logic        q_full;
    logic        q_empty;
    logic        pop;

    logic        h_write;
    logic [1:0]  h_size;
    logic        h_signed;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic        h_misaligned;
    logic [3:0]  h_be;
    logic [31:0] h_wd;

    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic        cmd_signed;
    logic [1:0]  cmd_lane;
    logic [CW-1:0] tcount;

    logic        read_q;
    logic        write_q;
    logic        rsp_valid_q;
    logic        rsp_error_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] address_q;
    logic [3:0]  be_q;
    logic [31:0] wd_q;

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    assign pop           = (state == IDLE) && !q_empty;
    assign bus.req_ready = !q_full;
    assign busy          = !q_empty || (state != IDLE);

    lsu_req_queue #(.DEPTH(DEPTH), .WIDTH(QW)) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (bus.req_valid),
        .pop   (pop),
        .wdata ({bus.req_write, bus.req_size, bus.req_signed, bus.req_addr, bus.req_wdata}),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty)
    );

    assign {h_write, h_size, h_signed, h_addr, h_wdata} = q_rdata;

    // Decode the queue head into lane enables and replicated write data
    always_comb begin
        h_misaligned = 1'b0;
        h_be         = 4'b0000;
        h_wd         = h_wdata;
        case (h_size)
            2'b00: begin
                h_be = 4'b0001 << h_addr[1:0];
                h_wd = {4{h_wdata[7:0]}};
            end
            2'b01: begin
                h_misaligned = h_addr[0];
                h_be         = h_addr[1] ? 4'b1100 : 4'b0011;
                h_wd         = {2{h_wdata[15:0]}};
            end
            2'b10: begin
                h_misaligned = (h_addr[1:0] != 2'b00);
                h_be         = 4'b1111;
            end
            default: h_misaligned = 1'b1;
        endcase
    end

    // Right-justify the addressed lane(s) of readdata and extend
    always_comb begin
        lane_byte = bus.readdata[7:0];
        case (cmd_lane)
            2'd1:    lane_byte = bus.readdata[15:8];
            2'd2:    lane_byte = bus.readdata[23:16];
            2'd3:    lane_byte = bus.readdata[31:24];
            default: lane_byte = bus.readdata[7:0];
        endcase
        lane_half = cmd_lane[1] ? bus.readdata[31:16] : bus.readdata[15:0];
        case (cmd_size)
            2'b00:   load_data = {{24{cmd_signed & lane_byte[7]}}, lane_byte};
            2'b01:   load_data = {{16{cmd_signed & lane_half[15]}}, lane_half};
            default: load_data = bus.readdata;
        endcase
    end

    // Command FSM with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tcount      <= '0;
            cmd_write   <= 1'b0;
            cmd_size    <= 2'b00;
            cmd_signed  <= 1'b0;
            cmd_lane    <= 2'b00;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            address_q   <= '0;
            be_q        <= '0;
            wd_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    rsp_error_q <= 1'b0;
                    if (!q_empty) begin
                        cmd_write  <= h_write;
                        cmd_size   <= h_size;
                        cmd_signed <= h_signed;
                        cmd_lane   <= h_addr[1:0];
                        if (h_misaligned) begin
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            state       <= RESP;
                        end else begin
                            address_q <= {h_addr[31:2], 2'b00};
                            be_q      <= h_be;
                            wd_q      <= h_wd;
                            read_q    <= !h_write;
                            write_q   <= h_write;
                            tcount    <= '0;
                            state     <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (!bus.waitrequest) begin
                        read_q      <= 1'b0;
                        write_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b0;
                        rsp_rdata_q <= cmd_write ? 32'h0 : load_data;
                        state       <= RESP;
                    end else if ((TIMEOUT != 0) && (tcount == TO_LIMIT)) begin
                        read_q      <= 1'b0;
                        write_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        state       <= RESP;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_error_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    state       <= IDLE;
                end
                default: begin
                    read_q      <= 1'b0;
                    write_q     <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_error  = rsp_error_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.address    = address_q;
    assign bus.byteenable = be_q;
    assign bus.writedata  = wd_q;
endmodule
